// File: rtl/icache_ctrl_if.sv
// Bus bundle for the instruction-cache sequencing controller.
// Carries the IF-stage request/response, the cache lookup/replace port and
// the byte-wide memory read port.
//   master : controller view (drives if_ready/if_inst, cache and memory requests)
//   slave  : environment view (IF stage, cache array, memory arbiter)
interface icache_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  // IF stage side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              flush;
  logic              if_ready;
  logic [INST_W-1:0] if_inst;
  // cache array side
  logic [ADDR_W-1:0] c_addr;
  logic [INST_W-1:0] c_data;
  logic              c_hit;
  logic [INST_W-1:0] c_wdata;
  logic              c_replace;
  // memory side
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_grant;
  logic [7:0]        mem_din;

  modport master (
    input  if_req, if_addr, flush, c_data, c_hit, mem_grant, mem_din,
    output if_ready, if_inst, c_addr, c_wdata, c_replace, mem_req, mem_addr
  );

  modport slave (
    output if_req, if_addr, flush, c_data, c_hit, mem_grant, mem_din,
    input  if_ready, if_inst, c_addr, c_wdata, c_replace, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_ctrl.sv
// Sequencing controller for a direct-mapped instruction cache.
// A lookup hit returns the cached word in the cycle after acceptance. A miss
// fetches the four bytes of the word over the byte-wide memory port,
// assembles them little-endian, writes the word into the cache and returns
// it. flush aborts any transaction in progress; a partial refill is dropped.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : icache_ctrl_if.master (IF request/response, cache port, memory port)
module icache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  icache_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    FETCH,
    REFILL
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        issue_cnt;
  logic [2:0]        recv_cnt;
  logic [INST_W-1:0] buffer;
  // A byte was granted last cycle, so mem_din carries it this cycle.
  logic              recv_pend;

  logic fetch_req;
  logic hit_ready;
  logic refill;
  logic unused_addr_bits;

  assign unused_addr_bits = ^bus.if_addr[1:0];

  assign fetch_req = (state == FETCH) && (issue_cnt < 3'd4) && !bus.flush;
  assign hit_ready = (state == LOOKUP) && bus.c_hit;
  assign refill    = (state == REFILL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_addr  <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      buffer    <= '0;
      recv_pend <= 1'b0;
    end else begin
      recv_pend <= 1'b0;
      if (bus.flush) begin
        // An outstanding byte still returns next cycle; recv_pend is dropped
        // so it is never written into the buffer.
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.if_req) begin
              req_addr <= {bus.if_addr[ADDR_W-1:2], 2'b00};
              state    <= LOOKUP;
            end
          end
          LOOKUP: begin
            if (bus.c_hit) begin
              state <= IDLE;
            end else begin
              issue_cnt <= '0;
              recv_cnt  <= '0;
              buffer    <= '0;
              state     <= FETCH;
            end
          end
          FETCH: begin
            if (fetch_req && bus.mem_grant) begin
              issue_cnt <= issue_cnt + 3'd1;
              recv_pend <= 1'b1;
            end
            if (recv_pend) begin
              buffer[{recv_cnt[1:0], 3'b000} +: 8] <= bus.mem_din;
              recv_cnt <= recv_cnt + 3'd1;
              if (recv_cnt == 3'd3) begin
                state <= REFILL;
              end
            end
          end
          REFILL: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Response strobes depend on same-cycle c_hit and flush, so they are decoded
  // from the registered state rather than registered themselves.
  assign bus.c_addr    = req_addr;
  assign bus.mem_req   = fetch_req;
  assign bus.mem_addr  = req_addr + ADDR_W'(issue_cnt);
  assign bus.c_wdata   = buffer;
  assign bus.c_replace = refill && !bus.flush;
  assign bus.if_ready  = (hit_ready || refill) && !bus.flush;
  assign bus.if_inst   = hit_ready ? bus.c_data :
                         refill    ? buffer     : '0;

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl. A small direct-mapped cache model and
// a byte memory model surround the controller; expected responses and refill
// words are queued when a request is issued and checked when the controller
// produces if_ready / c_replace.
module tb_icache_ctrl;
  localparam int AW = 32;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_ctrl_if #(.ADDR_W(AW), .INST_W(IW)) bus ();

  icache_ctrl #(.ADDR_W(AW), .INST_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // cache model: 16 lines indexed by address bits [5:2]
  logic [AW-1:0] ctag [16];
  logic [IW-1:0] cdat [16];
  logic          cval [16];
  logic [3:0]    cidx;

  always_comb begin
    cidx      = bus.c_addr[5:2];
    bus.c_hit = cval[cidx] && (ctag[cidx] == bus.c_addr);
    bus.c_data = cdat[cidx];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    int          lat;
    int          grants;
  } exp_t;

  exp_t        rdy_q [$];
  logic [31:0] rep_q [$];

  int          cyc = 0;
  int          acc_cyc = 0;
  int          denied = 0;
  int          issued = 0;
  int          grants = 0;
  int          rdy_cnt = 0;
  int          rep_cnt = 0;
  logic [AW-1:0] base = '0;
  logic        pend_v = 1'b0;
  logic [7:0]  pend_b = 8'h00;
  bit          alt_grant = 1'b0;
  bit          want_acc = 1'b0;
  bit          ready_seen = 1'b0;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h2004: return 8'h13;
      32'h2005: return 8'h05;
      32'h2006: return 8'h10;
      32'h2007: return 8'h00;
      32'h3000: return 8'hB7;
      32'h3001: return 8'h12;
      32'h3002: return 8'h34;
      32'h3003: return 8'h56;
      default:  return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  // One clock cycle: inputs applied at the falling edge, outputs sampled 1ns later.
  task automatic step(input logic req, input logic fl);
    exp_t e;
    @(negedge clk);
    bus.if_req    = req;
    bus.flush     = fl;
    bus.mem_din   = pend_v ? pend_b : 8'hEE;
    pend_v        = 1'b0;
    bus.mem_grant = alt_grant ? (cyc % 2 == 0) : 1'b1;
    #1;
    cyc++;
    if (fl)
      check("flush_suppress", {29'd0, bus.mem_req, bus.if_ready, bus.c_replace}, 32'd0);
    if (bus.mem_req && bus.mem_grant) begin
      check("mem_addr", bus.mem_addr, base + 32'(issued));
      issued++;
      grants++;
      pend_v = 1'b1;
      pend_b = mem_byte(bus.mem_addr);
    end
    if (bus.mem_req && !bus.mem_grant) denied++;
    if (bus.c_replace) begin
      rep_cnt++;
      if (rep_q.size() == 0) begin
        check("spurious_replace", 32'd1, 32'd0);
      end else begin
        check("c_wdata", bus.c_wdata, rep_q.pop_front());
        check("c_addr", bus.c_addr, base);
        ctag[bus.c_addr[5:2]] = bus.c_addr;
        cdat[bus.c_addr[5:2]] = bus.c_wdata;
        cval[bus.c_addr[5:2]] = 1'b1;
      end
    end
    if (bus.if_ready) begin
      rdy_cnt++;
      if (rdy_q.size() == 0) begin
        check("spurious_ready", 32'd1, 32'd0);
      end else begin
        e = rdy_q.pop_front();
        check("if_inst", bus.if_inst, e.inst);
        check("latency", 32'(cyc - acc_cyc), 32'(e.lat + denied));
        check("grant_count", 32'(grants), 32'(e.grants));
        ready_seen = 1'b1;
      end
    end
    if (want_acc && req && !fl) begin
      want_acc = 1'b0;
      acc_cyc  = cyc;
      base     = {bus.if_addr[AW-1:2], 2'b00};
      issued   = 0;
      denied   = 0;
      grants   = 0;
    end
  endtask

  task automatic run_req(input logic [31:0] addr, input bit flush_first);
    exp_t        e;
    logic [31:0] al;
    logic [3:0]  li;
    bit          hit;
    al  = {addr[31:2], 2'b00};
    li  = al[5:2];
    hit = cval[li] && (ctag[li] == al);
    e.inst   = hit ? cdat[li] : word_at(al);
    e.lat    = hit ? 1 : 7;
    e.grants = hit ? 0 : 4;
    rdy_q.push_back(e);
    if (!hit) rep_q.push_back(word_at(al));
    bus.if_addr = addr;
    want_acc    = 1'b1;
    ready_seen  = 1'b0;
    if (flush_first) step(1'b1, 1'b1);
    for (int i = 0; i < 60 && !ready_seen; i++) step(1'b1, 1'b0);
    if (!ready_seen) begin
      check("ready_timeout", 32'd0, 32'd1);
      rdy_q.delete();
      rep_q.delete();
    end
    step(1'b0, 1'b0);
  endtask

  task automatic outs_zero();
    check("rst_if_ready", {31'd0, bus.if_ready}, 32'd0);
    check("rst_if_inst", bus.if_inst, 32'd0);
    check("rst_c_replace", {31'd0, bus.c_replace}, 32'd0);
    check("rst_c_wdata", bus.c_wdata, 32'd0);
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_c_addr", bus.c_addr, 32'd0);
  endtask

  int r0;
  int c0;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ctag[i] = '0;
      cdat[i] = '0;
      cval[i] = 1'b0;
    end
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.flush     = 1'b0;
    bus.mem_grant = 1'b0;
    bus.mem_din   = 8'h00;
    rst = 1'b0;
    #3;
    outs_zero();
    @(negedge clk);
    rst = 1'b1;

    // preloaded hit
    ctag[0] = 32'h0000_1000;
    cdat[0] = 32'h00A0_0093;
    cval[0] = 1'b1;
    run_req(32'h0000_1000, 1'b0);

    // miss with continuous grant, then the same word hits (low bits ignored)
    run_req(32'h0000_2004, 1'b0);
    run_req(32'h0000_2006, 1'b0);

    // miss with alternating grant
    cval[1] = 1'b0;
    alt_grant = 1'b1;
    run_req(32'h0000_2004, 1'b0);
    alt_grant = 1'b0;

    // flush after two bytes granted
    r0 = rdy_cnt;
    c0 = rep_cnt;
    bus.if_addr = 32'h0000_3000;
    want_acc = 1'b1;
    grants = 0;
    for (int i = 0; i < 30 && grants < 2; i++) step(1'b1, 1'b0);
    check("flush_setup_grants", 32'(grants), 32'd2);
    step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    check("flush_no_ready", 32'(rdy_cnt - r0), 32'd0);
    check("flush_no_replace", 32'(rep_cnt - c0), 32'd0);
    run_req(32'h0000_3000, 1'b0);

    // request together with flush is not accepted
    run_req(32'h0000_2004, 1'b1);

    // asynchronous reset in the middle of a fetch
    bus.if_addr = 32'h0000_4000;
    want_acc = 1'b1;
    grants = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    check("rst_setup_grants", 32'(grants), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    outs_zero();
    want_acc = 1'b0;
    step(1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0);
    run_req(32'h0000_4000, 1'b0);

    check("ready_q_empty", 32'(rdy_q.size()), 32'd0);
    check("replace_q_empty", 32'(rep_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Sequencing controller for the direct-mapped instruction cache. It sits between the IF stage and the byte-wide memory port. On a lookup hit it returns the cached word. On a miss it fetches the 4 bytes of the word from memory, assembles them little-endian, writes the word into the cache, and returns it to IF. A pipeline flush (branch redirect) aborts any transaction in progress.

## Interface
Parameters:
- ADDR_W, 32, address width
- INST_W, 32, instruction/word width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  IF requests an instruction; held high until if_ready
- if_addr  in  ADDR_W  fetch PC; bits [1:0] ignored
- flush  in  1  abort current transaction (branch redirect)
- if_ready  out  1  one-cycle pulse: if_inst valid
- if_inst  out  INST_W  returned instruction
- c_addr  out  ADDR_W  address to cache lookup/replace port
- c_data  in  INST_W  cache read word (combinational from c_addr)
- c_hit  in  1  cache tag match and valid for c_addr (combinational)
- c_wdata  out  INST_W  refill word
- c_replace  out  1  cache write strobe for c_addr/c_wdata
- mem_req  out  1  byte read request
- mem_addr  out  ADDR_W  byte address
- mem_grant  in  1  memory arbiter accepts the request this cycle
- mem_din  in  8  read byte; valid exactly one cycle after its grant

## Operation
- States: IDLE, LOOKUP, FETCH, REFILL. Held registers:
  - req_addr (ADDR_W): word-aligned, {if_addr[ADDR_W-1:2],2'b00}
  - issue_cnt, recv_cnt (3 bits each, range 0..4)
  - word buffer (INST_W)
- c_addr = req_addr in all states.
- IDLE:
  - if_req=1 and flush=0: latch req_addr, go to LOOKUP.
  - Otherwise stay in IDLE.
- LOOKUP:
  - c_hit=1: if_ready=1, if_inst=c_data; go to IDLE.
  - c_hit=0: clear both counters and the buffer; go to FETCH.
- FETCH:
  - mem_req=1 while issue_cnt<4; mem_addr=req_addr+issue_cnt.
  - mem_req && mem_grant: issue_cnt increments.
  - The cycle after each grant: mem_din is written to buffer bits [8·recv_cnt+7 : 8·recv_cnt], and recv_cnt increments.
  - recv_cnt reaches 4: go to REFILL.
  - Grants are allowed back-to-back; issue and receive may occur in the same cycle.
- REFILL (one cycle):
  - c_replace=1, c_wdata=buffer.
  - if_ready=1, if_inst=buffer.
  - Go to IDLE.
- if_addr changes after acceptance are ignored until the next IDLE acceptance.
- flush=1 in any state:
  - Next state is IDLE.
  - Combinational outputs are suppressed in that same cycle: if_ready=0, c_replace=0, mem_req=0.
  - A byte already granted returns during IDLE and is discarded. A partial refill is never written.
- Simultaneous if_req and flush in IDLE: flush wins; the request is not accepted.

## Timing
- Reset (rst=0, asynchronous):
  - State becomes IDLE; counters, req_addr and buffer become 0.
  - Outputs read 0: if_ready, if_inst, c_replace, c_wdata, mem_req, mem_addr=0, c_addr=0.
  - Reset during FETCH abandons the transfer; a late mem_din is ignored.
- Hit latency: accept edge → if_ready in the LOOKUP cycle (1 cycle after acceptance).
- Miss latency with continuous grant: 1 (LOOKUP) + 5 (FETCH: 4 issues, last byte arrives a cycle later) + 1 (REFILL) = if_ready 7 cycles after acceptance. Each denied grant adds 1 cycle.
- if_ready and c_replace are single-cycle pulses. A new request is accepted no earlier than the cycle after if_ready.
- mem_din is sampled only in the cycle following a granted mem_req.

## Test plan
- Hit: cache preloaded with tag for 0x00001000 holding 0x00A00093. Request 0x1000 → if_ready 1 cycle after accept, if_inst=0x00A00093, no mem_req.
- Miss, full grant: request 0x2004 with memory bytes 0x13,0x05,0x10,0x00 → mem_addr 0x2004..0x2007 on consecutive cycles. Then c_replace=1 with c_wdata=0x00100513, and if_ready 7 cycles after accept. Repeating the request then hits.
- Stalled grant: same miss with mem_grant low on alternating cycles → bytes still assemble to 0x00100513, and if_ready is delayed by exactly the number of denied cycles.
- Flush mid-FETCH after 2 bytes → IDLE next cycle, no c_replace, no if_ready. Next request to 0x3000 refetches from byte 0 and returns correct data.
- Simultaneous if_req+flush in IDLE → no acceptance. Request held next cycle (flush=0) → accepted.
- Async rst pulse low mid-FETCH (between clock edges) → outputs 0 immediately. After release, a new miss completes correctly.
